// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, word width and instruction lengths.
// Codes 0xC-0xF have no name; they fall through to a one-byte length.
package y86_pkg;

  localparam int WORD_W = 64;

  typedef logic [3:0] icode_t;

  localparam icode_t I_HALT   = 4'h0;
  localparam icode_t I_NOP    = 4'h1;
  localparam icode_t I_RRMOVQ = 4'h2;
  localparam icode_t I_IRMOVQ = 4'h3;
  localparam icode_t I_RMMOVQ = 4'h4;
  localparam icode_t I_MRMOVQ = 4'h5;
  localparam icode_t I_OPQ    = 4'h6;
  localparam icode_t I_JXX    = 4'h7;
  localparam icode_t I_CALL   = 4'h8;
  localparam icode_t I_RET    = 4'h9;
  localparam icode_t I_PUSHQ  = 4'hA;
  localparam icode_t I_POPQ   = 4'hB;

  // Encoded byte length of the instruction; unknown codes advance by one byte.
  function automatic logic [3:0] instr_len(input icode_t ic);
    logic [3:0] len;
    case (ic)
      I_HALT, I_NOP, I_RET:                 len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         len = 4'd10;
      I_JXX, I_CALL:                        len = 4'd9;
      default:                              len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/pc_incre.sv
// Fall-through address: current PC plus the length of the instruction at PC.
// The sum wraps modulo 2^W without any overflow indication.
module pc_incre
  import y86_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] pc_i,
  input  icode_t       icode_i,
  output logic [W-1:0] valp_o
);

  logic [3:0] len;

  assign len    = instr_len(icode_i);
  assign valp_o = pc_i + {{(W-4){1'b0}}, len};

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, fall-through adder and next-PC select.
// Halt freezes the PC by reselecting the current value; there is no stall input.
module pc_unit
  import y86_pkg::*;
#(
  parameter int           W        = WORD_W,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  icode_t       icode,
  input  logic         Cnd,
  input  logic [W-1:0] valC,
  input  logic [W-1:0] valM,
  output logic [W-1:0] PC,
  output logic [W-1:0] valP,
  output logic [W-1:0] NEW_PC
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  pc_incre #(.W(W)) u_pc_incre (
    .pc_i    (pc_q),
    .icode_i (icode),
    .valp_o  (valP)
  );

  // Priority: halt, call, taken jump, ret, otherwise fall through.
  always_comb begin
    pc_d = valP;
    case (icode)
      I_HALT:  pc_d = pc_q;
      I_CALL:  pc_d = valC;
      I_JXX:   pc_d = Cnd ? valC : valP;
      I_RET:   pc_d = valM;
      default: pc_d = valP;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign PC     = pc_q;
  assign NEW_PC = pc_d;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, fall-through, branch, call/ret, halt, wrap, invalid codes.
module tb_pc_unit;

  localparam int W = 64;

  logic         CLK;
  logic         RST_N;
  logic [3:0]   icode;
  logic         Cnd;
  logic [W-1:0] valC;
  logic [W-1:0] valM;
  logic [W-1:0] PC;
  logic [W-1:0] valP;
  logic [W-1:0] NEW_PC;

  int total = 0;
  int bad   = 0;

  pc_unit #(.W(W), .RESET_PC('0)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .icode  (icode),
    .Cnd    (Cnd),
    .valC   (valC),
    .valM   (valM),
    .PC     (PC),
    .valP   (valP),
    .NEW_PC (NEW_PC)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Checking
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic c,
                       input logic [W-1:0] vc, input logic [W-1:0] vm);
    icode = ic;
    Cnd   = c;
    valC  = vc;
    valM  = vm;
    #1;
  endtask

  // Load an arbitrary PC by issuing a call to it
  task automatic set_pc(input logic [W-1:0] a);
    drive(4'h8, 1'b0, a, '0);
    tick();
    check("set_pc", PC, a);
  endtask

  int lens [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  initial begin
    RST_N = 1'b0;
    drive(4'h1, 1'b0, '0, '0);

    // Reset held across edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_pc", PC, 64'h0);
    end
    check("rst_valp", valP, 64'h1);
    check("rst_newpc", NEW_PC, 64'h1);

    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check("rel_pc", PC, 64'h1);

    // Fall-through from a clean PC=0
    RST_N = 1'b0;
    #1;
    check("rst_async", PC, 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check("nop_pc0", PC, 64'h1);
    drive(4'h3, 1'b0, '0, '0);
    check("irmov_valp", valP, 64'hB);
    tick();
    check("irmov_pc", PC, 64'hB);

    // Conditional jump taken / not taken
    set_pc(64'h20);
    drive(4'h7, 1'b1, 64'h100, '0);
    check("jxx_t_newpc", NEW_PC, 64'h100);
    tick();
    check("jxx_t_pc", PC, 64'h100);
    set_pc(64'h20);
    drive(4'h7, 1'b0, 64'h100, '0);
    check("jxx_n_newpc", NEW_PC, 64'h29);
    tick();
    check("jxx_n_pc", PC, 64'h29);

    // Call then ret; Cnd must not matter for ret
    set_pc(64'h50);
    drive(4'h8, 1'b0, 64'h200, '0);
    tick();
    check("call_pc", PC, 64'h200);
    drive(4'h9, 1'b1, 64'h999, 64'h59);
    check("ret_newpc", NEW_PC, 64'h59);
    tick();
    check("ret_pc", PC, 64'h59);

    // Halt freezes the PC
    set_pc(64'h30);
    drive(4'h0, 1'b1, 64'h777, 64'h888);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_pc", PC, 64'h30);
      check("halt_valp", valP, 64'h31);
    end

    // Wraparound
    set_pc(64'hFFFF_FFFF_FFFF_FFFF);
    drive(4'h1, 1'b0, '0, '0);
    check("wrap_valp", valP, 64'h0);
    tick();
    check("wrap_pc", PC, 64'h0);

    // Invalid codes fall through by one byte, ignoring Cnd/valC
    set_pc(64'h10);
    drive(4'hE, 1'b1, 64'h444, 64'h555);
    check("inv_valp", valP, 64'h11);
    check("inv_newpc", NEW_PC, 64'h11);
    tick();
    check("inv_pc", PC, 64'h11);

    // Length table for every code at a fixed PC
    set_pc(64'h1000);
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0, 64'h1000, 64'h1000);
      check($sformatf("len_%0h", i), valP, 64'h1000 + 64'(lens[i]));
    end

    // Reset asserted mid-cycle overrides the pending update
    set_pc(64'h40);
    drive(4'h1, 1'b0, '0, '0);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_pc", PC, 64'h0);
    check("mid_rst_newpc", NEW_PC, 64'h1);
    tick();
    check("mid_rst_hold", PC, 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(4'h6, 1'b0, '0, '0);
    tick();
    check("post_rst_pc", PC, 64'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
